branch_predictor: RTL and testbench
===================================

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter BHT_ADDR_BITS, default 4: table index width; table holds 2^BHT_ADDR_BITS entries.
REQ-002 SHALL have parameter CTR_BITS, default 2: width of each saturating counter, legal range 1..4.
REQ-003 SHALL have parameter GHR_BITS, default 4: global history width, legal range 1..BHT_ADDR_BITS.
REQ-004 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 SHALL have port resetn, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port lk_PC, input, 32: byte address of the instruction being looked up.
REQ-007 SHALL have port lk_predict, output, 1: 1 = predict taken.
REQ-008 SHALL have port lk_index, output, BHT_ADDR_BITS: table index used for this lookup, carried down the pipe by the user.
REQ-009 SHALL have port up_valid, input, 1: a resolved branch updates the table this cycle.
REQ-010 SHALL have port up_index, input, BHT_ADDR_BITS: entry to update, equal to the lk_index captured at lookup.
REQ-011 SHALL have port up_taken, input, 1: actual branch outcome.
REQ-012 SHALL have port up_predict, input, 1: prediction that was made for this branch.
REQ-013 SHALL have port ready, output, 1: 1 once the table initialisation sweep has finished.
REQ-014 SHALL have port stat_branches, output, 32: count of accepted updates.
REQ-015 SHALL have port stat_hits, output, 32: count of accepted updates with up_taken == up_predict.

Function
REQ-016 SHALL compute base index as lk_PC[BHT_ADDR_BITS+1:2].
REQ-017 SHALL drive lk_predict combinationally from the MSB of the addressed counter while in RUN, and drive it 0 while in INIT.
REQ-018 SHALL implement a two-state FSM: INIT sweeps pointer 0..2^BHT_ADDR_BITS-1, writing one entry per cycle with the weak-not-taken value 2^(CTR_BITS-1)-1; after the last entry it enters RUN; RUN persists until reset.
REQ-019 SHALL hold ready at 0 in INIT and at 1 in RUN, so ready rises exactly 2^BHT_ADDR_BITS cycles after resetn deasserts.
REQ-020 SHALL, on up_valid in RUN, increment counter[up_index] when up_taken = 1 and decrement it otherwise, saturating at 2^CTR_BITS-1 and at 0.
REQ-021 SHALL ignore up_valid during INIT: no counter, history or statistics change.
REQ-022 SHALL take effect on the next cycle: a lookup and an update to the same index in the same cycle return the pre-update counter, with no bypass.
REQ-023 SHALL, on each accepted update, increment stat_branches and, if up_taken == up_predict, increment stat_hits; both counters saturate at 0xFFFFFFFF.
REQ-024 SHALL keep a lookup latency of 0 cycles and an update latency of 1 cycle.

Reset
REQ-025 SHALL, while resetn = 0, immediately force state INIT, sweep pointer 0, ready 0, lk_predict 0, GHR 0, stat_branches 0 and stat_hits 0.
REQ-026 SHALL treat assertion of resetn during a sweep or in RUN identically: the sweep restarts from entry 0 after release.
REQ-027 SHALL not rely on reset for table contents; only the INIT sweep defines them.

Configuration
REQ-028 SHALL use macro BP_GSHARE_EN to select gshare indexing.
REQ-029 SHALL, with BP_GSHARE_EN defined, keep a GHR_BITS global history register, shift up_taken into its LSB on each accepted update, and form lk_index as the base index XOR the zero-extended GHR.
REQ-030 SHALL, without BP_GSHARE_EN, have no GHR and set lk_index equal to the base index.

Verification (defaults: BHT_ADDR_BITS=4, CTR_BITS=2, GHR_BITS=4)
REQ-031 SHALL verify that releasing resetn gives ready = 0 for 16 cycles, then ready = 1, with lk_predict = 0 throughout INIT for any lk_PC.
REQ-032 SHALL verify, without gshare and with lk_PC=0x0C (index 3), that two taken updates to index 3 give lk_predict = 1, a third taken update leaves the counter at 3, and one following not-taken update still gives lk_predict = 1.
REQ-033 SHALL verify that an update to index 5 during INIT is ignored: after ready rises, lk_predict = 0 for lk_PC=0x14 and both statistics read 0.
REQ-034 SHALL verify, with gshare, that two taken updates (GHR = 0b0011) followed by lk_PC=0x10 give lk_index = 7; without gshare the same stimulus gives lk_index = 4.
REQ-035 SHALL verify that 10 accepted updates, 7 of them with up_taken == up_predict, give stat_branches = 10 and stat_hits = 7.
REQ-036 SHALL verify that asserting resetn low while the sweep pointer is at 9 drops ready immediately, clears the statistics, and ready then rises 16 cycles after release.

Source files
------------

// File: rtl/branch_predictor.sv
// Bimodal/gshare branch predictor with a sweep-initialised saturating-counter table.
// Define BP_GSHARE_EN to XOR a global history register into the lookup index.
module branch_predictor #(
    parameter int BHT_ADDR_BITS = 4,
    parameter int CTR_BITS      = 2,
    parameter int GHR_BITS      = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [31:0]              lk_PC,
    output logic                     lk_predict,
    output logic [BHT_ADDR_BITS-1:0] lk_index,
    input  logic                     up_valid,
    input  logic [BHT_ADDR_BITS-1:0] up_index,
    input  logic                     up_taken,
    input  logic                     up_predict,
    output logic                     ready,
    output logic [31:0]              stat_branches,
    output logic [31:0]              stat_hits
);

    localparam int                     ENTRIES = 1 << BHT_ADDR_BITS;
    localparam logic [CTR_BITS-1:0]    CTR_MAX = '1;
    localparam logic [CTR_BITS-1:0]    CTR_WNT = CTR_MAX >> 1;

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t                   state_q, state_d;
    logic [BHT_ADDR_BITS-1:0] ptr_q, ptr_d;
    logic [31:0]              branches_q, branches_d;
    logic [31:0]              hits_q, hits_d;
    logic [CTR_BITS-1:0]      ctr_q [ENTRIES];

    logic                     wr_en;
    logic [BHT_ADDR_BITS-1:0] wr_idx;
    logic [CTR_BITS-1:0]      wr_val;
    logic [CTR_BITS-1:0]      cur;
    logic [BHT_ADDR_BITS-1:0] base_idx;
    logic                     upd_acc;

    // Only the word-index bits of the PC participate in indexing.
    logic unused_pc;
    assign unused_pc = ^{lk_PC[31:BHT_ADDR_BITS+2], lk_PC[1:0]};

    assign base_idx = lk_PC[BHT_ADDR_BITS+1:2];
    assign upd_acc  = (state_q == S_RUN) && up_valid;

`ifdef BP_GSHARE_EN
    logic [GHR_BITS-1:0] ghr_q, ghr_d;
    logic [GHR_BITS:0]   ghr_shift;

    assign ghr_shift = {ghr_q, up_taken};
    assign ghr_d     = upd_acc ? ghr_shift[GHR_BITS-1:0] : ghr_q;
    assign lk_index  = base_idx ^ {{(BHT_ADDR_BITS-GHR_BITS){1'b0}}, ghr_q};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) ghr_q <= '0;
        else         ghr_q <= ghr_d;
    end
`else
    assign lk_index = base_idx;
`endif

    assign ready         = (state_q == S_RUN);
    assign lk_predict    = (state_q == S_RUN) && ctr_q[lk_index][CTR_BITS-1];
    assign stat_branches = branches_q;
    assign stat_hits     = hits_q;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        branches_d = branches_q;
        hits_d     = hits_q;
        wr_en      = 1'b0;
        wr_idx     = ptr_q;
        wr_val     = CTR_WNT;
        cur        = ctr_q[up_index];
        case (state_q)
            S_INIT: begin
                wr_en = 1'b1;
                ptr_d = ptr_q + BHT_ADDR_BITS'(1);
                if (ptr_q == '1) state_d = S_RUN;
            end
            S_RUN: begin
                if (up_valid) begin
                    wr_en  = 1'b1;
                    wr_idx = up_index;
                    if (up_taken) wr_val = (cur == CTR_MAX) ? cur : cur + CTR_BITS'(1);
                    else          wr_val = (cur == '0)      ? cur : cur - CTR_BITS'(1);
                    if (branches_q != '1) branches_d = branches_q + 32'd1;
                    if ((up_taken == up_predict) && (hits_q != '1)) hits_d = hits_q + 32'd1;
                end
            end
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_INIT;
            ptr_q      <= '0;
            branches_q <= '0;
            hits_q     <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            branches_q <= branches_d;
            hits_q     <= hits_d;
        end
    end

    // Table contents are defined solely by the INIT sweep, so no reset here.
    always_ff @(posedge clk) begin
        if (wr_en) ctr_q[wr_idx] <= wr_val;
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed, table-driven bench for branch_predictor at default parameters.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] lk_PC = '0;
    logic        lk_predict;
    logic [3:0]  lk_index;
    logic        up_valid = 1'b0;
    logic [3:0]  up_index = '0;
    logic        up_taken = 1'b0;
    logic        up_predict = 1'b0;
    logic        ready;
    logic [31:0] stat_branches;
    logic [31:0] stat_hits;

    int n_cmp = 0;
    int n_bad = 0;
    logic [3:0] exp_ghr = '0;

    branch_predictor #(.BHT_ADDR_BITS(4), .CTR_BITS(2), .GHR_BITS(4)) dut (
        .clk(clk), .resetn(resetn), .lk_PC(lk_PC), .lk_predict(lk_predict),
        .lk_index(lk_index), .up_valid(up_valid), .up_index(up_index),
        .up_taken(up_taken), .up_predict(up_predict), .ready(ready),
        .stat_branches(stat_branches), .stat_hits(stat_hits)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] lk_idx;
        logic       uv;
        logic [3:0] ui;
        logic       ut;
        logic       up;
        logic       exp_pred;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // PC that lands on a desired table index given the history the bench expects.
    function automatic logic [31:0] pc_of(input logic [3:0] idx);
`ifdef BP_GSHARE_EN
        return {26'd0, idx ^ exp_ghr, 2'b00};
`else
        return {26'd0, idx, 2'b00};
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic update(input logic [3:0] idx, input logic t, input logic p);
        up_valid = 1'b1; up_index = idx; up_taken = t; up_predict = p;
        tick();
        exp_ghr = {exp_ghr[2:0], t};
        up_valid = 1'b0;
    endtask

    // Releases reset and checks ready is low for 16 cycles then high.
    task automatic release_and_sweep(input string tag, input logic upd_in_init);
        @(negedge clk);
        resetn = 1'b1;
        exp_ghr = '0;
        for (int i = 0; i < 16; i++) begin
            lk_PC = $urandom;
            up_valid = upd_in_init; up_index = 4'd5; up_taken = 1'b1; up_predict = 1'b1;
            #1;
            check($sformatf("%s_ready_init%0d", tag, i), {31'd0, ready}, 32'd0);
            check($sformatf("%s_pred_init%0d", tag, i), {31'd0, lk_predict}, 32'd0);
            tick();
        end
        up_valid = 1'b0;
        check($sformatf("%s_ready_run", tag), {31'd0, ready}, 32'd1);
    endtask

    vec_t vecs [13];

    initial begin
        // Counters start at weak-not-taken (1). Updates: 10, hits: 7.
        vecs[0]  = '{4'd3, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{4'd3, 1'b1, 4'd3, 1'b1, 1'b0, 1'b1};
        vecs[2]  = '{4'd3, 1'b1, 4'd3, 1'b1, 1'b1, 1'b1};
        vecs[3]  = '{4'd3, 1'b1, 4'd3, 1'b0, 1'b1, 1'b1};
        vecs[4]  = '{4'd3, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{4'd6, 1'b1, 4'd6, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{4'd6, 1'b1, 4'd6, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{4'd6, 1'b1, 4'd6, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{4'd6, 1'b1, 4'd6, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{4'd6, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{4'd3, 1'b1, 4'd3, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{4'd3, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{4'd3, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};

        // Reset state
        lk_PC = 32'h0C;
        #12;
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_pred", {31'd0, lk_predict}, 32'd0);
        check("rst_branches", stat_branches, 32'd0);
        check("rst_hits", stat_hits, 32'd0);

        // Sweep with an update to index 5 attempted throughout INIT
        release_and_sweep("sweep1", 1'b1);
        lk_PC = 32'h14;
        #1;
        check("init_upd_ignored_pred", {31'd0, lk_predict}, 32'd0);
        check("init_upd_ignored_branches", stat_branches, 32'd0);
        check("init_upd_ignored_hits", stat_hits, 32'd0);

        // Counter behaviour: lookup sees the pre-update value in the same cycle
        for (int i = 0; i < 13; i++) begin
            lk_PC = pc_of(vecs[i].lk_idx);
            up_valid = vecs[i].uv; up_index = vecs[i].ui;
            up_taken = vecs[i].ut; up_predict = vecs[i].up;
            #1;
            check($sformatf("vec%0d_pred", i), {31'd0, lk_predict}, {31'd0, vecs[i].exp_pred});
            check($sformatf("vec%0d_index", i), {28'd0, lk_index}, {28'd0, vecs[i].lk_idx});
            tick();
            if (vecs[i].uv) exp_ghr = {exp_ghr[2:0], vecs[i].ut};
        end
        up_valid = 1'b0;
        check("stat_branches_10", stat_branches, 32'd10);
        check("stat_hits_7", stat_hits, 32'd7);

        // Reset in RUN clears statistics immediately
        resetn = 1'b0;
        #1;
        check("run_rst_ready", {31'd0, ready}, 32'd0);
        check("run_rst_branches", stat_branches, 32'd0);
        check("run_rst_hits", stat_hits, 32'd0);
        release_and_sweep("sweep2", 1'b0);

        // History-indexed lookup after two taken updates
        update(4'd0, 1'b1, 1'b1);
        update(4'd0, 1'b1, 1'b1);
        lk_PC = 32'h10;
        #1;
`ifdef BP_GSHARE_EN
        check("gshare_index", {28'd0, lk_index}, 32'd7);
`else
        check("bimodal_index", {28'd0, lk_index}, 32'd4);
`endif
        check("post_stat_branches", stat_branches, 32'd2);
        check("post_stat_hits", stat_hits, 32'd2);

        // Reset mid-sweep with pointer at 9, then full restart
        resetn = 1'b0;
        #1;
        resetn = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 9; i++) tick();
        resetn = 1'b0;
        #1;
        check("mid_rst_ready", {31'd0, ready}, 32'd0);
        check("mid_rst_branches", stat_branches, 32'd0);
        check("mid_rst_hits", stat_hits, 32'd0);
        release_and_sweep("sweep3", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
